// File: rtl/frame_compositor.sv
// Frame compositor: sweeps the render area once per vs falling edge, fetches the
// cloud/map/hero layers per pixel and writes the transparency-resolved index.
module frame_compositor #(
    parameter int unsigned FRAME_W  = 256,
    parameter int unsigned FRAME_H  = 256,
    parameter logic [3:0]  BG_INDEX = 4'h1,
    parameter logic [3:0]  TRANSP   = 4'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        vs,
    output logic [15:0] CLOUD_COORD,
    input  logic [3:0]  CLOUD_DATA,
    output logic [15:0] MAP_COORD,
    input  logic [3:0]  MAP_DATA,
    output logic [15:0] HERO_COORD,
    input  logic [3:0]  HERO_DATA,
    output logic [1:0]  SPRITE_SEL,
    output logic        RENDER_EN,
    output logic [3:0]  RENDER_DATA,
    output logic [7:0]  RENDER_X,
    output logic [7:0]  RENDER_Y,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic [7:0]  OVERRUN_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PH_A  = 3'd1,
        ST_PH_B  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    localparam logic [7:0] X_LAST = 8'(FRAME_W - 32'd1);
    localparam logic [7:0] Y_LAST = 8'(FRAME_H - 32'd1);

    state_t      state_r;
    state_t      state_s;
    logic        vs_d_r;
    logic        start_s;
    logic        write_s;
    logic        x_wrap_s;
    logic        y_wrap_s;
    logic [1:0]  sel_s;
    logic [7:0]  x_r;
    logic [7:0]  y_r;
    logic        last_issued_r;
    logic [15:0] coord_r;
    logic [1:0]  sel_r;
    logic [3:0]  cloud_r;
    logic [3:0]  map_r;
    logic [7:0]  pend_x_r;
    logic [7:0]  pend_y_r;
    logic        pend_valid_r;
    logic        render_en_r;
    logic [3:0]  render_data_r;
    logic [7:0]  render_x_r;
    logic [7:0]  render_y_r;
    logic        busy_r;
    logic        frame_done_r;
    logic [7:0]  overrun_r;

    // Hero over map over cloud over background.
    function automatic logic [3:0] compose(input logic [3:0] hero,
                                           input logic [3:0] map,
                                           input logic [3:0] cloud);
        logic [3:0] pix;
        if (hero != TRANSP) begin
            pix = hero;
        end else if (map != TRANSP) begin
            pix = map;
        end else if (cloud != TRANSP) begin
            pix = cloud;
        end else begin
            pix = BG_INDEX;
        end
        return pix;
    endfunction

    assign start_s  = vs_d_r & ~vs;
    assign write_s  = ((state_r == ST_PH_A) && pend_valid_r) || (state_r == ST_DRAIN);
    assign x_wrap_s = (x_r == X_LAST);
    assign y_wrap_s = (y_r == Y_LAST);

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_PH_A;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PH_A: state_s = ST_PH_B;
            ST_PH_B: begin
                if (last_issued_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_PH_A;
                end
            end
            ST_DRAIN: state_s = ST_FLUSH;
            ST_FLUSH: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Sprite-ROM arbiter grant for the upcoming cycle.
    always_comb begin
        sel_s = 2'b00;
        case (state_s)
            ST_PH_A: sel_s = 2'b01;
            ST_PH_B: sel_s = 2'b10;
            default: sel_s = 2'b00;
        endcase
    end

    // State register and vs edge-detect delay.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            vs_d_r  <= 1'b1;
            sel_r   <= 2'b00;
        end else begin
            state_r <= state_s;
            vs_d_r  <= vs;
            sel_r   <= sel_s;
        end
    end

    // Scan counters point at the next pixel to issue; COORD is loaded on entry to phase A.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            x_r           <= 8'd0;
            y_r           <= 8'd0;
            last_issued_r <= 1'b0;
            coord_r       <= 16'd0;
        end else if (state_s == ST_PH_A) begin
            coord_r       <= {y_r, x_r};
            last_issued_r <= x_wrap_s && y_wrap_s;
            if (x_wrap_s) begin
                x_r <= 8'd0;
                y_r <= y_wrap_s ? 8'd0 : (y_r + 8'd1);
            end else begin
                x_r <= x_r + 8'd1;
            end
        end else if ((state_s == ST_IDLE) || (state_s == ST_FLUSH)) begin
            x_r           <= 8'd0;
            y_r           <= 8'd0;
            last_issued_r <= 1'b0;
            coord_r       <= 16'd0;
        end else begin
            coord_r <= coord_r;
        end
    end

    // Layer capture: cloud/map in phase B, hero one phase later alongside the write.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cloud_r       <= 4'd0;
            map_r         <= 4'd0;
            pend_x_r      <= 8'd0;
            pend_y_r      <= 8'd0;
            pend_valid_r  <= 1'b0;
            render_en_r   <= 1'b0;
            render_data_r <= 4'd0;
            render_x_r    <= 8'd0;
            render_y_r    <= 8'd0;
        end else begin
            render_en_r <= write_s;
            if (state_r == ST_PH_B) begin
                cloud_r      <= CLOUD_DATA;
                map_r        <= MAP_DATA;
                pend_x_r     <= coord_r[7:0];
                pend_y_r     <= coord_r[15:8];
                pend_valid_r <= 1'b1;
            end else if (write_s || (state_r == ST_IDLE)) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
            if (write_s) begin
                render_data_r <= compose(HERO_DATA, map_r, cloud_r);
                render_x_r    <= pend_x_r;
                render_y_r    <= pend_y_r;
            end else begin
                render_data_r <= render_data_r;
            end
        end
    end

    // Status: busy, done pulse and saturating dropped-start count.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 8'd0;
        end else begin
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_r == ST_FLUSH);
            if (start_s && (state_r != ST_IDLE) && (overrun_r != 8'hFF)) begin
                overrun_r <= overrun_r + 8'd1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign CLOUD_COORD = coord_r;
    assign MAP_COORD   = coord_r;
    assign HERO_COORD  = coord_r;
    assign SPRITE_SEL  = sel_r;
    assign RENDER_EN   = render_en_r;
    assign RENDER_DATA = render_data_r;
    assign RENDER_X    = render_x_r;
    assign RENDER_Y    = render_y_r;
    assign BUSY        = busy_r;
    assign FRAME_DONE  = frame_done_r;
    assign OVERRUN_CNT = overrun_r;

endmodule
